// File: rtl/vga_fifo_fill_ctrl_pkg.sv
// Shared definitions for the VGA pixel-FIFO controllers: fill FSM state codes
// and the FIFO size / free-space width helpers.
package vga_fifo_fill_ctrl_pkg;

   typedef logic [1:0] fill_state_t;

   localparam fill_state_t ST_IDLE  = 2'd0;
   localparam fill_state_t ST_REQ   = 2'd1;
   localparam fill_state_t ST_FLUSH = 2'd2;

   function automatic int fifo_size(input int ptr_size);
      return 1 << ptr_size;
   endfunction

   // One extra bit over the depth width for the sign of a transiently negative free count.
   function automatic int free_w(input int ptr_size);
      return ptr_size + 2;
   endfunction

endpackage

// File: rtl/vga_fifo_fill_ctrl_space.sv
// Free-space arithmetic for the pixel FIFO: free = size - depth - outstanding,
// and whether that leaves room for one more burst plus the reporting margin.
module vga_fifo_fill_ctrl_space
   import vga_fifo_fill_ctrl_pkg::*;
#(
   parameter int FIFO_PTR_SIZE = 8,
   parameter int BURST_LEN     = 16,
   parameter int MARGIN        = 2
) (
   input  logic [FIFO_PTR_SIZE:0] depth,
   input  logic [FIFO_PTR_SIZE:0] outstanding,
   output logic                   space_ok
);

   localparam int FW = free_w(FIFO_PTR_SIZE);
   localparam logic signed [FW-1:0] SIZE_S = FW'(fifo_size(FIFO_PTR_SIZE));
   localparam logic signed [FW-1:0] NEED_S = FW'(BURST_LEN + MARGIN);

   logic signed [FW-1:0] depth_s;
   logic signed [FW-1:0] out_s;
   logic signed [FW-1:0] free_s;

   always_comb begin
      depth_s  = $signed({1'b0, depth});
      out_s    = $signed({1'b0, outstanding});
      free_s   = SIZE_S - depth_s - out_s;
      space_ok = (free_s >= NEED_S);
   end

endmodule

// File: rtl/vga_fifo_fill_ctrl.sv
// Write-side fill controller: issues Avalon-MM burst reads over a linear frame
// buffer whenever the pixel FIFO has room, and pushes returned beats into it.
module vga_fifo_fill_ctrl
   import vga_fifo_fill_ctrl_pkg::*;
#(
   parameter int FIFO_PTR_SIZE = 8,
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 32,
   parameter int BURST_LEN     = 16,
   parameter int BURST_W       = 5,
   parameter int MARGIN        = 2,
   parameter int FRAME_W       = 20
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [ADDR_W-1:0]        frame_base,
   input  logic [FRAME_W-1:0]       frame_words,
   input  logic                     frame_restart,
   input  logic [FIFO_PTR_SIZE:0]   fifo_depth_of,
   input  logic                     fifo_full,
   output logic                     fifo_wr_valid,
   output logic [DATA_W-1:0]        fifo_wr_data,
   output logic [ADDR_W-1:0]        avm_address,
   output logic                     avm_read,
   output logic [BURST_W-1:0]       avm_burstcount,
   input  logic                     avm_waitrequest,
   input  logic [DATA_W-1:0]        avm_readdata,
   input  logic                     avm_readdatavalid,
   output logic [FIFO_PTR_SIZE:0]   outstanding,
   output logic                     busy,
   output logic                     overflow_err
);

   localparam int OW         = FIFO_PTR_SIZE + 1;
   localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

   fill_state_t         state_q,       state_d;
   logic                avm_read_q,    avm_read_d;
   logic [FRAME_W-1:0]  word_idx_q,    word_idx_d;
   logic [ADDR_W-1:0]   base_q,        base_d;
   logic [FRAME_W-1:0]  len_q,         len_d;
   logic [ADDR_W-1:0]   pend_base_q,   pend_base_d;
   logic [FRAME_W-1:0]  pend_len_q,    pend_len_d;
   logic                started_q,     started_d;
   logic [OW-1:0]       outstanding_q, outstanding_d;
   logic                wr_valid_q,    wr_valid_d;
   logic [DATA_W-1:0]   wr_data_q,     wr_data_d;
   logic                overflow_q,    overflow_d;

   logic                space_ok;
   logic                accept;
   logic [FRAME_W-1:0]  idx_step;
   logic [FRAME_W-1:0]  idx_adv;

   vga_fifo_fill_ctrl_space #(
      .FIFO_PTR_SIZE (FIFO_PTR_SIZE),
      .BURST_LEN     (BURST_LEN),
      .MARGIN        (MARGIN)
   ) u_space (
      .depth       (fifo_depth_of),
      .outstanding (outstanding_q),
      .space_ok    (space_ok)
   );

   always_comb begin
      state_d       = state_q;
      avm_read_d    = avm_read_q;
      word_idx_d    = word_idx_q;
      base_d        = base_q;
      len_d         = len_q;
      pend_base_d   = pend_base_q;
      pend_len_d    = pend_len_q;
      started_d     = started_q;

      accept   = avm_read_q && !avm_waitrequest;
      idx_step = word_idx_q + FRAME_W'(BURST_LEN);
      idx_adv  = (idx_step >= len_q) ? '0 : idx_step;

      outstanding_d = outstanding_q
                    + (accept            ? OW'(BURST_LEN) : '0)
                    - (avm_readdatavalid ? OW'(1)         : '0);

      // Beats belonging to the abandoned frame are dropped while flushing.
      wr_valid_d = avm_readdatavalid && (state_q != ST_FLUSH);
      wr_data_d  = avm_readdata;
      overflow_d = overflow_q | (wr_valid_q & fifo_full);

      if (accept) begin
         avm_read_d = 1'b0;
         word_idx_d = idx_adv;
      end

      if (frame_restart) begin
         pend_base_d = frame_base;
         pend_len_d  = frame_words;
      end

      case (state_q)
         ST_IDLE: begin
            if (frame_restart) begin
               if (outstanding_q == '0) begin
                  base_d     = frame_base;
                  len_d      = frame_words;
                  word_idx_d = '0;
                  started_d  = 1'b1;
               end else begin
                  state_d = ST_FLUSH;
               end
            end else if (started_q && enable && space_ok) begin
               avm_read_d = 1'b1;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            // An unaccepted request rides into FLUSH and is finished there.
            if (frame_restart) begin
               state_d = ST_FLUSH;
            end else if (accept) begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (!avm_read_q && (outstanding_q == '0)) begin
               base_d     = pend_base_d;
               len_d      = pend_len_d;
               word_idx_d = '0;
               started_d  = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            avm_read_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         avm_read_q    <= 1'b0;
         word_idx_q    <= '0;
         base_q        <= '0;
         len_q         <= '0;
         pend_base_q   <= '0;
         pend_len_q    <= '0;
         started_q     <= 1'b0;
         outstanding_q <= '0;
         wr_valid_q    <= 1'b0;
         wr_data_q     <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         avm_read_q    <= avm_read_d;
         word_idx_q    <= word_idx_d;
         base_q        <= base_d;
         len_q         <= len_d;
         pend_base_q   <= pend_base_d;
         pend_len_q    <= pend_len_d;
         started_q     <= started_d;
         outstanding_q <= outstanding_d;
         wr_valid_q    <= wr_valid_d;
         wr_data_q     <= wr_data_d;
         overflow_q    <= overflow_d;
      end
   end

   always_comb begin
      avm_address    = base_q + (ADDR_W'(word_idx_q) << BYTE_SHIFT);
      avm_read       = avm_read_q;
      avm_burstcount = BURST_W'(BURST_LEN);
      fifo_wr_valid  = wr_valid_q;
      fifo_wr_data   = wr_data_q;
      outstanding    = outstanding_q;
      busy           = (state_q != ST_IDLE) || (outstanding_q != '0);
      overflow_err   = overflow_q;
   end

endmodule

// File: tb/tb_vga_fifo_fill_ctrl.sv
// Directed bench for vga_fifo_fill_ctrl: fill, data return, wrap, stall,
// restart flush, overflow flag and the free-space threshold.
module tb_vga_fifo_fill_ctrl;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [31:0] frame_base;
   logic [19:0] frame_words;
   logic        frame_restart;
   logic [8:0]  fifo_depth_of;
   logic        fifo_full;
   logic        fifo_wr_valid;
   logic [31:0] fifo_wr_data;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [4:0]  avm_burstcount;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic [8:0]  outstanding;
   logic        busy;
   logic        overflow_err;

   vga_fifo_fill_ctrl dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .enable            (enable),
      .frame_base        (frame_base),
      .frame_words       (frame_words),
      .frame_restart     (frame_restart),
      .fifo_depth_of     (fifo_depth_of),
      .fifo_full         (fifo_full),
      .fifo_wr_valid     (fifo_wr_valid),
      .fifo_wr_data      (fifo_wr_data),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_burstcount    (avm_burstcount),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .outstanding       (outstanding),
      .busy              (busy),
      .overflow_err      (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int wr_cnt = 0;
   logic [31:0] acc_addr[$];

   always @(posedge clk) begin
      if (reset_n && avm_read && !avm_waitrequest) begin
         acc_addr.push_back(avm_address);
         acc_cnt <= acc_cnt + 1;
         $display("burst accepted addr=0x%08h count=%0d", avm_address, avm_burstcount);
      end
      if (fifo_wr_valid) wr_cnt <= wr_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          base_cnt;
      int          wr_base;
      logic [31:0] hold_addr;
      logic        stable;
      logic        leaked;

      reset_n = 1'b0; enable = 1'b0; frame_base = '0; frame_words = '0;
      frame_restart = 1'b0; fifo_depth_of = '0; fifo_full = 1'b0;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
      repeat (3) tick();
      chk("rst_read", avm_read, 0);
      chk("rst_addr", avm_address, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_valid", fifo_wr_valid, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      chk("rst_overflow", overflow_err, 0);
      chk("burstcount", avm_burstcount, 16);

      // Without a restart nothing may be issued.
      reset_n = 1'b1; enable = 1'b1;
      repeat (5) tick();
      chk("no_issue_before_restart", acc_cnt, 0);

      // Fill: 15 bursts bring outstanding to 240, beyond which free < 18.
      frame_base = 32'h1000; frame_words = 20'd64; frame_restart = 1'b1;
      tick();
      frame_restart = 1'b0;
      repeat (60) tick();
      chk("fill_bursts", acc_cnt, 15);
      chk("fill_outstanding", outstanding, 240);
      chk("fill_read_low", avm_read, 0);
      for (int i = 0; i < acc_addr.size(); i++)
         chk($sformatf("fill_addr%0d", i), acc_addr[i], 32'h1000 + (i % 4) * 32'h40);

      // Returned beats appear one cycle later, in order.
      enable = 1'b0;
      for (int i = 0; i < 16; i++) begin
         avm_readdatavalid = 1'b1;
         avm_readdata = 32'hA0 + i;
         tick();
         chk($sformatf("beat%0d_valid", i), fifo_wr_valid, 1);
         chk($sformatf("beat%0d_data", i), fifo_wr_data, 32'hA0 + i);
      end
      avm_readdatavalid = 1'b0;
      tick();
      chk("beat_valid_drop", fifo_wr_valid, 0);
      chk("beat_wr_count", wr_cnt, 16);
      chk("beat_outstanding", outstanding, 224);

      avm_readdatavalid = 1'b1;
      repeat (224) tick();
      avm_readdatavalid = 1'b0;
      tick();
      chk("drain_outstanding", outstanding, 0);
      chk("drain_busy", busy, 0);

      // Stalled request: next address is word 48 of the frame.
      base_cnt = acc_cnt;
      avm_waitrequest = 1'b1; enable = 1'b1;
      for (int i = 0; i < 10 && !avm_read; i++) tick();
      chk("stall_req_seen", avm_read, 1);
      hold_addr = avm_address;
      enable = 1'b0;
      stable = 1'b1;
      repeat (5) begin
         tick();
         if (avm_read !== 1'b1 || avm_address !== hold_addr) stable = 1'b0;
      end
      chk("stall_stable", stable, 1);
      chk("stall_addr", hold_addr, 32'h10C0);
      chk("stall_no_accept", acc_cnt, base_cnt);
      chk("stall_outstanding", outstanding, 0);
      avm_waitrequest = 1'b0;
      tick();
      chk("stall_single_accept", acc_cnt, base_cnt + 1);
      chk("stall_outstanding_after", outstanding, 16);
      chk("stall_read_low", avm_read, 0);
      repeat (5) tick();
      chk("disabled_no_issue", acc_cnt, base_cnt + 1);

      // One more burst: wraps to the frame start, 32 words now in flight.
      enable = 1'b1;
      for (int i = 0; i < 10 && acc_cnt == base_cnt + 1; i++) tick();
      enable = 1'b0;
      chk("wrap_accept", acc_cnt, base_cnt + 2);
      chk("wrap_addr", acc_addr[acc_addr.size() - 1], 32'h1000);
      chk("wrap_outstanding", outstanding, 32);

      // Restart with 32 outstanding: beats discarded, new frame after drain.
      base_cnt = acc_cnt; wr_base = wr_cnt; enable = 1'b1;
      frame_base = 32'h8000; frame_words = 20'd64; frame_restart = 1'b1;
      tick();
      frame_restart = 1'b0;
      chk("flush_busy", busy, 1);
      leaked = 1'b0;
      avm_readdatavalid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         avm_readdata = 32'hB00 + i;
         tick();
         if (fifo_wr_valid) leaked = 1'b1;
      end
      avm_readdatavalid = 1'b0;
      chk("flush_no_issue", acc_cnt, base_cnt);
      chk("flush_outstanding", outstanding, 0);
      tick();
      if (fifo_wr_valid) leaked = 1'b1;
      chk("flush_discard", leaked, 0);
      chk("flush_wr_count", wr_cnt, wr_base);
      for (int i = 0; i < 10 && acc_cnt == base_cnt; i++) tick();
      enable = 1'b0;
      chk("flush_next_accept", acc_cnt, base_cnt + 1);
      chk("flush_next_addr", acc_addr[acc_addr.size() - 1], 32'h8000);
      chk("flush_next_outstanding", outstanding, 16);

      // A write while full raises the sticky flag; the write still happens.
      chk("ovf_before", overflow_err, 0);
      wr_base = wr_cnt;
      fifo_full = 1'b1;
      avm_readdatavalid = 1'b1; avm_readdata = 32'h55;
      tick();
      avm_readdatavalid = 1'b0;
      tick();
      tick();
      chk("ovf_set", overflow_err, 1);
      chk("ovf_write_issued", wr_cnt, wr_base + 1);
      fifo_full = 1'b0;
      repeat (5) tick();
      chk("ovf_sticky", overflow_err, 1);
      reset_n = 1'b0;
      tick();
      chk("ovf_cleared_by_reset", overflow_err, 0);
      chk("reset2_outstanding", outstanding, 0);
      chk("reset2_busy", busy, 0);

      // Free-space threshold: 17 free blocks issue, 18 free allows it.
      reset_n = 1'b1; fifo_depth_of = 9'd239; enable = 1'b1;
      frame_base = 32'h2000; frame_words = 20'd16; frame_restart = 1'b1;
      tick();
      frame_restart = 1'b0;
      base_cnt = acc_cnt;
      repeat (8) tick();
      chk("space17_blocked", acc_cnt, base_cnt);
      chk("space17_read_low", avm_read, 0);
      fifo_depth_of = 9'd238;
      for (int i = 0; i < 10 && acc_cnt == base_cnt; i++) tick();
      enable = 1'b0;
      chk("space18_accept", acc_cnt, base_cnt + 1);
      chk("space18_addr", acc_addr[acc_addr.size() - 1], 32'h2000);
      chk("short_frame_wrap", avm_address, 32'h2000);
      chk("space18_outstanding", outstanding, 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_fifo_fill_ctrl.md
Name: vga_fifo_fill_ctrl

Overview:
Write-side controller for the pixel async FIFO. It watches the FIFO write-side depth and schedules Avalon-MM burst reads from frame memory so the FIFO stays topped up for the VGA read side. It walks the frame buffer linearly, wraps at end of frame and restarts on a frame-restart pulse. Returned beats are pushed into the FIFO via its update_valid/data path.

Parameters:
FIFO_PTR_SIZE, 8, FIFO address bits; FIFO_SIZE = 1<<FIFO_PTR_SIZE words
DATA_W, 32, memory/FIFO word width
ADDR_W, 32, byte address width
BURST_LEN, 16, words per burst; power of 2, <= FIFO_SIZE/2
BURST_W, 5, avm_burstcount width; holds BURST_LEN
MARGIN, 2, extra free words required before issuing; covers depth-reporting lag
FRAME_W, 20, width of the frame word count

Ports:
clk  in  1  write-side clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; 0 = issue no new bursts (in-flight beats still complete)
frame_base  in  ADDR_W  byte address of frame start, word aligned; sampled on restart
frame_words  in  FRAME_W  words per frame, multiple of BURST_LEN, nonzero; sampled on restart
frame_restart  in  1  one-cycle pulse, synchronous to clk; rewind to frame_base
fifo_depth_of  in  FIFO_PTR_SIZE+1  write-side occupancy from FIFO pointer logic
fifo_full  in  1  write-side full flag
fifo_wr_valid  out  1  FIFO write strobe (drives update_valid)
fifo_wr_data  out  DATA_W  FIFO write data
avm_address  out  ADDR_W  burst start byte address
avm_read  out  1  read request
avm_burstcount  out  BURST_W  constant BURST_LEN
avm_waitrequest  in  1  slave stall
avm_readdata  in  DATA_W  returned data
avm_readdatavalid  in  1  returned beat valid
outstanding  out  FIFO_PTR_SIZE+1  words requested, not yet returned
busy  out  1  state != IDLE or outstanding != 0
overflow_err  out  1  sticky; beat returned while fifo_full

Behaviour:
- Reset (async, reset_n=0): state=IDLE, avm_read=0, avm_address=0, fifo_wr_valid=0, fifo_wr_data=0, outstanding=0, overflow_err=0, busy=0, word pointer=0, base/length registers=0. The first frame_restart after reset is required before any issue.
- Registers: base_r, len_r, word_idx (FRAME_W). avm_address = base_r + word_idx*(DATA_W/8). Multiply-by-shift is implemented; DATA_W must be a power of 2.
- Space check: free = FIFO_SIZE - fifo_depth_of - outstanding. Compute at FIFO_PTR_SIZE+2 bits, signed-safe. A burst may issue only when free >= BURST_LEN + MARGIN.
- FSM states:
  - IDLE: if started && enable && space ok && !frame_restart -> REQ. avm_read=1 is registered at entry.
  - REQ: hold avm_read/avm_address/avm_burstcount stable while avm_waitrequest=1. On the cycle avm_waitrequest=0: avm_read<=0, outstanding += BURST_LEN, word_idx += BURST_LEN, and word_idx wraps to 0 when it reaches len_r. Then -> IDLE. The request is never withdrawn once asserted.
  - FLUSH: entered on frame_restart from any state. If in REQ with the request not yet accepted, the request is held until accepted (Avalon rule), then counted. Stay in FLUSH until outstanding==0. Beats in FLUSH are discarded (no fifo_wr_valid). On exit: word_idx=0, base_r/len_r reload from the values captured at the restart pulse, started=1, -> IDLE.
  - frame_restart while in IDLE with outstanding==0 reloads directly, in the same cycle; no FLUSH.
- Data path: fifo_wr_valid <= avm_readdatavalid && state!=FLUSH, registered with fifo_wr_data <= avm_readdata. Latency 1 cycle.
- outstanding: -1 per readdatavalid beat, in all states. Burst acceptance and a beat in the same cycle give a net +BURST_LEN-1.
- overflow_err: set if fifo_wr_valid is written while fifo_full=1. Cleared only by reset. The write is still issued; the pointer block owns protection.
- enable deasserted mid-REQ: the request completes; no further issue.
- Max one burst in flight per decision. Multiple outstanding bursts are allowed, bounded by the space check.

Decomposition:
- Shared package: FSM state enum {IDLE, REQ, FLUSH}, and a localparam function for FIFO_SIZE / free-space width. The VGA read-side controller reuses it.
- No sub-module required. An optional fill_space_calc (free-space arithmetic plus compare) is natural if the read-side controller needs the same check.

Test Plan:
- Reset then restart (base=0x1000, words=64, depth=0, enable=1, waitrequest=0) -> bursts at 0x1000, 0x1040, 0x1080, …; avm_burstcount=16. Issue stops once outstanding + depth > 256-18.
- Slave returns 16 beats 0xA0..0xAF, one per cycle -> fifo_wr_valid for 16 consecutive cycles, each 1 cycle after its beat, data in order; outstanding goes 16→0.
- Frame of 64 words, FIFO drained continuously -> after the 4th burst (0x10C0), the next address is 0x1000 (wrap).
- waitrequest held high 5 cycles during REQ -> avm_read/address stable all 5 cycles; a single acceptance; outstanding +16 exactly once.
- frame_restart with 32 words outstanding, new base=0x8000 -> 32 beats discarded (fifo_wr_valid=0). The next burst is at 0x8000 only after outstanding=0.
- Force fifo_full=1 during a returned beat -> overflow_err=1 and remains 1 until reset_n low.
